// File: rtl/tetris_io_pkg.sv
// Shared constants for the board-facing I/O blocks: stretcher state encoding and default timing.
package tetris_io_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StOn   = ST_ON,
    StGap  = ST_GAP
  } stretch_state_e;

  localparam int unsigned CLK_HZ              = 65_000_000;
  localparam int unsigned STRETCH_ON_DEFAULT  = CLK_HZ / 10;  // 100 ms
  localparam int unsigned STRETCH_GAP_DEFAULT = CLK_HZ / 20;  // 50 ms

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/event_stretcher_if.sv
// Event-strobe in, stretched level and status out. Dropped exists only with
// EVENT_STRETCHER_DROP_FLAG_EN defined.
interface event_stretcher_if #(
  parameter int unsigned PEND_W = 3
);
  logic              pulse;
  logic              out;
  logic              busy;
  logic [PEND_W-1:0] pending;
`ifdef EVENT_STRETCHER_DROP_FLAG_EN
  logic              dropped;

  modport master (output pulse, input out, input busy, input pending, input dropped);
  modport slave  (input pulse, output out, output busy, output pending, output dropped);
`else
  modport master (output pulse, input out, input busy, input pending);
  modport slave  (input pulse, output out, output busy, output pending);
`endif
endinterface

// File: rtl/phase_timer.sv
// Free-running phase counter with synchronous clear; done flags the terminal count.
module phase_timer #(
  parameter int unsigned CNT_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] tc_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clear_i ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == tc_i);

endmodule

// File: rtl/event_stretcher.sv
// Turns one-cycle event strobes into fixed-width level pulses, queueing overlapping events.
// Optional sticky overflow flag enabled by EVENT_STRETCHER_DROP_FLAG_EN.
module event_stretcher
  import tetris_io_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = STRETCH_ON_DEFAULT,
  parameter int unsigned GAP_CYCLES = STRETCH_GAP_DEFAULT,
  parameter int unsigned CNT_W      = 23,
  parameter int unsigned PEND_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  event_stretcher_if.slave bus
);

  localparam logic [PEND_W-1:0] PendMax = '1;
  localparam logic [CNT_W-1:0]  OnTc    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GapTc   = CNT_W'(GAP_CYCLES - 1);

  stretch_state_e    state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              out_q, busy_q;
  logic              clear, done, enq, deq;
  logic [CNT_W-1:0]  tc;

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .tc_i    (tc),
    .done_o  (done)
  );

  // From IDLE an event starts its pulse directly and is never counted as pending.
  assign enq = bus.pulse && (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    clear   = 1'b0;
    tc      = OnTc;
    deq     = 1'b0;
    unique case (state_q)
      StIdle: begin
        clear = 1'b1;
        if (bus.pulse) state_d = StOn;
      end
      StOn: begin
        if (done) begin
          state_d = StGap;
          clear   = 1'b1;
        end
      end
      StGap: begin
        tc = GapTc;
        if (done) begin
          clear = 1'b1;
          // An event landing on the last gap cycle is consumed immediately.
          if (pend_q != '0 || enq) begin
            deq     = 1'b1;
            state_d = StOn;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (enq && !deq) begin
      if (pend_q != PendMax) pend_d = pend_q + PEND_W'(1);
    end else if (!enq && deq) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pend_q  <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      out_q   <= (state_d == StOn);
      busy_q  <= (state_d != StIdle);
    end
  end

  assign bus.out     = out_q;
  assign bus.busy    = busy_q;
  assign bus.pending = pend_q;

`ifdef EVENT_STRETCHER_DROP_FLAG_EN
  logic drop, dropped_q;

  assign drop = enq && !deq && (pend_q == PendMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropped_q <= 1'b0;
    end else if (drop) begin
      dropped_q <= 1'b1;
    end
  end

  assign bus.dropped = dropped_q;
`endif

endmodule
